// File: rtl/sram_controller_pwr_sched.sv
// Power-request scheduler for the SRAM power FSM: idle-timeout auto-sleep, minimum sleep dwell,
// vote-driven wake with source capture. Define SRAM_PWR_SCHED_ACK_TIMEOUT_EN for the ack watchdog.
module sram_controller_pwr_sched #(
    parameter int NUM_REQ          = 4,
    parameter int CNT_W            = 16,
    parameter int IDLE_CYCLES      = 64,
    parameter int MIN_SLEEP_CYCLES = 16,
    parameter int ACK_TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] keep_awake,
    input  logic               bus_busy,
    input  logic               sleep_allow,
    input  logic [1:0]         fsm_state,
    output logic               pwr_save_req,
    output logic               pwr_restore_req,
    output logic [NUM_REQ-1:0] wake_src,
    output logic               wake_done,
    output logic [2:0]         sched_state,
    output logic               ack_timeout
);

    // Request/ack: a request is a level held from the cycle after the decision until the
    // edge that samples the acknowledging fsm_state (SLEEP for save, WAKEUP/ACTIVE for restore).
    typedef enum logic [2:0] {
        ST_MON      = 3'd0,
        ST_SAVE     = 3'd1,
        ST_SLEEPING = 3'd2,
        ST_RESTORE  = 3'd3,
        ST_WAKING   = 3'd4
    } state_e;

    localparam logic [1:0] FSM_ACTIVE  = 2'b00;
    localparam logic [1:0] FSM_SLEEP   = 2'b01;
    localparam logic [1:0] FSM_WAKEUP  = 2'b10;
    localparam logic [1:0] FSM_INVALID = 2'b11;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(MIN_SLEEP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);

`ifdef SRAM_PWR_SCHED_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic               retry_q, retry_d;
    logic               save_req_q, save_req_d;
    logic               restore_req_q, restore_req_d;
    logic [NUM_REQ-1:0] wake_src_q, wake_src_d;
    logic               wake_done_q, wake_done_d;
    logic               ack_timeout_q, ack_timeout_d;

    logic any_vote;
    logic idle;
    logic abort;
    logic save_ack;
    logic restore_ack;
    logic dwell_met;
    logic to_fire;
    logic in_req_state;

    always_comb begin
        any_vote     = |keep_awake;
        idle         = !any_vote && !bus_busy && sleep_allow && (fsm_state == FSM_ACTIVE);
        abort        = any_vote || bus_busy;
        save_ack     = (fsm_state == FSM_SLEEP);
        restore_ack  = (fsm_state == FSM_WAKEUP) || (fsm_state == FSM_ACTIVE);
        dwell_met    = (dwell_cnt_q >= DWELL_MIN);
        in_req_state = (state_q == ST_SAVE) || (state_q == ST_RESTORE);
        // The retry cycle itself never counts towards a timeout.
        to_fire      = TO_EN && in_req_state && !retry_q && (to_cnt_q == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_MON;
            idle_cnt_q    <= '0;
            dwell_cnt_q   <= '0;
            to_cnt_q      <= '0;
            retry_q       <= 1'b0;
            save_req_q    <= 1'b0;
            restore_req_q <= 1'b0;
            wake_src_q    <= '0;
            wake_done_q   <= 1'b0;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            to_cnt_q      <= to_cnt_d;
            retry_q       <= retry_d;
            save_req_q    <= save_req_d;
            restore_req_q <= restore_req_d;
            wake_src_q    <= wake_src_d;
            wake_done_q   <= wake_done_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fsm_state == FSM_INVALID) begin
            state_d = ST_MON;
        end else begin
            unique case (state_q)
                ST_MON: begin
                    if (idle && (idle_cnt_q == IDLE_LAST)) state_d = ST_SAVE;
                end
                ST_SAVE: begin
                    // An ack in the same cycle as an abort still completes the save.
                    if (save_ack)              state_d = ST_SLEEPING;
                    else if (to_fire || abort) state_d = ST_MON;
                end
                ST_SLEEPING: begin
                    if (fsm_state == FSM_ACTIVE)   state_d = ST_MON;
                    else if (any_vote && dwell_met) state_d = ST_RESTORE;
                end
                ST_RESTORE: begin
                    if (restore_ack) state_d = ST_WAKING;
                end
                ST_WAKING: begin
                    if (fsm_state == FSM_ACTIVE) state_d = ST_MON;
                end
                default: state_d = ST_MON;
            endcase
        end
    end

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_MON && idle) idle_cnt_d = idle_cnt_q + CNT_W'(1);

        dwell_cnt_d = '0;
        if (state_q == ST_SLEEPING) dwell_cnt_d = dwell_met ? dwell_cnt_q : dwell_cnt_q + CNT_W'(1);

        retry_d = TO_EN && (state_q == ST_RESTORE) && (state_d == ST_RESTORE) && to_fire;

        to_cnt_d = '0;
        if (TO_EN && in_req_state && (state_d == state_q) && !to_fire && !retry_q)
            to_cnt_d = to_cnt_q + CNT_W'(1);

        ack_timeout_d = ack_timeout_q;
        if (to_fire && !((state_q == ST_SAVE && save_ack) || (state_q == ST_RESTORE && restore_ack)))
            ack_timeout_d = 1'b1;

        wake_src_d = wake_src_q;
        if (state_q == ST_SLEEPING && state_d == ST_RESTORE) wake_src_d = keep_awake;

        save_req_d    = (state_d == ST_SAVE);
        restore_req_d = (state_d == ST_RESTORE) && !retry_d;
        wake_done_d   = (state_q == ST_WAKING) && (fsm_state == FSM_ACTIVE);
    end

    assign pwr_save_req    = save_req_q;
    assign pwr_restore_req = restore_req_q;
    assign wake_src        = wake_src_q;
    assign wake_done       = wake_done_q;
    assign sched_state     = state_q;
    assign ack_timeout     = TO_EN ? ack_timeout_q : 1'b0;

endmodule
